// File: rtl/picc_pkg.sv
// Shared constants and FSM state encoding for the PICC interrupt sequencer.
package picc_pkg;
  localparam int NUM_IRQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    VECTOR = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] PRI_NONE = 3'd7;
endpackage

// File: rtl/picc_ffs8.sv
// Find-first-set encoder: lowest set bit of an 8-bit vector (bit 0 wins), purely combinational.
module picc_ffs8 (
  input  logic [7:0] in_vec,
  output logic [2:0] idx,
  output logic       vld
);
  always_comb begin
    idx = 3'd0;
    vld = |in_vec;
    for (int i = 7; i >= 0; i--) begin
      if (in_vec[i]) idx = 3'(i);
    end
  end
endmodule

// File: rtl/picc_isr_ctrl.sv
// Interrupt sequencer: IRR latch, fixed-priority nesting, ack/vector handshake, ISR with EOI.
// ir edge -> IRR next edge -> int_o one edge later; vector pulses the cycle after int_ack.
module picc_isr_ctrl #(
  parameter int                 NUM_IRQ  = 8,
  parameter int                 VEC_W    = 8,
  parameter logic [VEC_W-1:0]   VEC_BASE = 8'h20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_IRQ-1:0]          ir,
  input  logic [NUM_IRQ-1:0]          mask,
  input  logic [NUM_IRQ-1:0]          trig_mode,
  output logic                        int_o,
  input  logic                        int_ack,
  output logic                        vec_valid,
  output logic [VEC_W-1:0]            vec_out,
  output logic                        spurious,
  input  logic                        eoi,
  input  logic                        eoi_specific,
  input  logic [picc_pkg::IDX_W-1:0]  eoi_id,
  output logic [NUM_IRQ-1:0]          isr_o,
  output logic [picc_pkg::IDX_W-1:0]  cur_pri,
  output logic                        in_service
);
  import picc_pkg::*;

  localparam logic [NUM_IRQ-1:0] ONE = {{(NUM_IRQ-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] ir_q, ir_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic               int_o_q, int_o_d;
  logic               vec_valid_q, vec_valid_d;
  logic               spurious_q, spurious_d;
  logic [VEC_W-1:0]   vec_out_q, vec_out_d;

  logic [NUM_IRQ-1:0] cand;
  logic [IDX_W-1:0]   win_idx, isr_idx;
  logic               win_vld, isr_vld, allowed, ack_take;
  logic [NUM_IRQ-1:0] ack_set, eoi_clr, edge_set;

  assign cand = irr_q & mask & ~isr_q;

  picc_ffs8 u_ffs_win (.in_vec(cand),  .idx(win_idx), .vld(win_vld));
  picc_ffs8 u_ffs_isr (.in_vec(isr_q), .idx(isr_idx), .vld(isr_vld));

  assign cur_pri    = isr_vld ? isr_idx : PRI_NONE;
  assign in_service = isr_vld;
  assign isr_o      = isr_q;

  // Nesting: only a strictly higher priority than the current in-service level may interrupt.
  assign allowed  = win_vld && (!isr_vld || (win_idx < cur_pri));
  assign ack_take = (state_q == ASSERT) && int_ack && allowed;
  assign ack_set  = ack_take ? (ONE << win_idx) : '0;

  always_comb begin
    ir_d     = ir;
    edge_set = ir & ~ir_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      irr_d[i] = trig_mode[i] ? (edge_set[i] | (irr_q[i] & ~ack_set[i])) : ir[i];
    end
  end

  // EOI acts on the pre-ack ISR; the newly acknowledged bit is merged afterwards.
  always_comb begin
    eoi_clr = '0;
    if (eoi) begin
      if (eoi_specific)  eoi_clr = ONE << eoi_id;
      else if (isr_vld)  eoi_clr = ONE << isr_idx;
    end
    isr_d = (isr_q & ~eoi_clr) | ack_set;
  end

  always_comb begin
    state_d     = state_q;
    int_o_d     = int_o_q;
    vec_valid_d = 1'b0;
    spurious_d  = 1'b0;
    vec_out_d   = vec_out_q;
    case (state_q)
      IDLE: begin
        if (allowed) begin
          state_d = ASSERT;
          int_o_d = 1'b1;
        end
      end
      ASSERT: begin
        if (int_ack) begin
          state_d     = VECTOR;
          int_o_d     = 1'b0;
          vec_valid_d = 1'b1;
          if (allowed) begin
            vec_out_d = VEC_BASE + VEC_W'(win_idx);
          end else begin
            vec_out_d  = VEC_BASE + VEC_W'(PRI_NONE);
            spurious_d = 1'b1;
          end
        end else if (!allowed) begin
          state_d = IDLE;
          int_o_d = 1'b0;
        end
      end
      VECTOR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        int_o_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ir_q        <= '0;
      irr_q       <= '0;
      isr_q       <= '0;
      int_o_q     <= 1'b0;
      vec_valid_q <= 1'b0;
      spurious_q  <= 1'b0;
      vec_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      int_o_q     <= int_o_d;
      vec_valid_q <= vec_valid_d;
      spurious_q  <= spurious_d;
      vec_out_q   <= vec_out_d;
    end
  end

  assign int_o     = int_o_q;
  assign vec_valid = vec_valid_q;
  assign spurious  = spurious_q;
  assign vec_out   = vec_out_q;
endmodule

// File: tb/tb_picc_isr_ctrl.sv
// Directed bench for picc_isr_ctrl with hand-computed expectations.
module tb_picc_isr_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ir, mask, trig_mode;
  logic       int_o, int_ack, vec_valid, spurious;
  logic [7:0] vec_out, isr_o;
  logic       eoi, eoi_specific, in_service;
  logic [2:0] eoi_id, cur_pri;

  int n_chk = 0;
  int n_err = 0;

  picc_isr_ctrl dut (
    .clk(clk), .rst(rst), .ir(ir), .mask(mask), .trig_mode(trig_mode),
    .int_o(int_o), .int_ack(int_ack), .vec_valid(vec_valid), .vec_out(vec_out),
    .spurious(spurious), .eoi(eoi), .eoi_specific(eoi_specific), .eoi_id(eoi_id),
    .isr_o(isr_o), .cur_pri(cur_pri), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle ir pulse; returns after the edge where int_o would first rise.
  task automatic pulse_ir(input logic [7:0] bits);
    ir = bits;
    step();
    ir = 8'h00;
    step();
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
  endtask

  task automatic do_eoi(input logic spec, input logic [2:0] id);
    eoi = 1'b1; eoi_specific = spec; eoi_id = id;
    step();
    eoi = 1'b0; eoi_specific = 1'b0; eoi_id = 3'd0;
  endtask

  initial begin
    rst = 1'b1; ir = 8'h00; mask = 8'hFF; trig_mode = 8'hFF;
    int_ack = 1'b0; eoi = 1'b0; eoi_specific = 1'b0; eoi_id = 3'd0;
    step(); step();
    check("rst_int_o", int_o, 0);
    check("rst_vec_valid", vec_valid, 0);
    check("rst_vec_out", vec_out, 8'h00);
    check("rst_isr", isr_o, 8'h00);
    check("rst_cur_pri", cur_pri, 3'd7);
    check("rst_in_service", in_service, 0);
    rst = 1'b0;
    step();

    // ack in IDLE is ignored
    do_ack();
    check("idle_ack_vv", vec_valid, 0);
    check("idle_ack_isr", isr_o, 8'h00);
    step();

    // 1: edge ir3
    ir = 8'h08;
    step();
    ir = 8'h00;
    check("t1_int_early", int_o, 0);
    step();
    check("t1_int_o", int_o, 1);
    do_ack();
    check("t1_vv", vec_valid, 1);
    check("t1_vec", vec_out, 8'h23);
    check("t1_isr", isr_o, 8'h08);
    check("t1_int_low", int_o, 0);
    check("t1_spur", spurious, 0);
    step();
    check("t1_vv_pulse", vec_valid, 0);
    do_eoi(1'b0, 3'd0);
    check("t1_eoi_isr", isr_o, 8'h00);
    step(); step();
    check("t1_irr_cleared", int_o, 0);

    // 2: nesting below/above ir5
    pulse_ir(8'h20);
    check("t2_int5", int_o, 1);
    do_ack();
    check("t2_vec5", vec_out, 8'h25);
    check("t2_isr5", isr_o, 8'h20);
    check("t2_pri5", cur_pri, 3'd5);
    step();
    pulse_ir(8'h40);
    step();
    check("t2_ir6_held", int_o, 0);
    pulse_ir(8'h04);
    check("t2_int2", int_o, 1);
    do_ack();
    check("t2_vec2", vec_out, 8'h22);
    check("t2_isr24", isr_o, 8'h24);
    check("t2_pri2", cur_pri, 3'd2);
    step();

    // 3: level ir1 withdrawn before ack -> spurious
    trig_mode = 8'hFD;
    ir = 8'h02;
    step();
    step();
    check("t3_int", int_o, 1);
    ir = 8'h00;
    step();
    check("t3_int_hold", int_o, 1);
    do_ack();
    check("t3_vv", vec_valid, 1);
    check("t3_vec", vec_out, 8'h27);
    check("t3_spur", spurious, 1);
    check("t3_isr", isr_o, 8'h24);
    step();
    check("t3_spur_pulse", spurious, 0);
    trig_mode = 8'hFF;

    // 4: EOI variants; pending ir6 releases once ISR empties
    do_eoi(1'b0, 3'd0);
    check("t4_ns", isr_o, 8'h20);
    check("t4_ns_pri", cur_pri, 3'd5);
    do_eoi(1'b1, 3'd5);
    check("t4_spec", isr_o, 8'h00);
    check("t4_spec_pri", cur_pri, 3'd7);
    do_eoi(1'b0, 3'd0);
    check("t4_empty", isr_o, 8'h00);
    check("t4_in_service", in_service, 0);
    check("t4_ir6_released", int_o, 1);
    do_ack();
    check("t4_vec6", vec_out, 8'h26);
    check("t4_isr6", isr_o, 8'h40);
    do_eoi(1'b1, 3'd2);
    check("t4_spec_clear_bit", isr_o, 8'h40);
    do_eoi(1'b0, 3'd0);
    check("t4_drain", isr_o, 8'h00);
    step();

    // 5: simultaneous ir0/ir7
    pulse_ir(8'h81);
    check("t5_int", int_o, 1);
    do_ack();
    check("t5_vec0", vec_out, 8'h20);
    check("t5_isr0", isr_o, 8'h01);
    step(); step(); step();
    check("t5_ir7_held", int_o, 0);
    do_eoi(1'b0, 3'd0);
    check("t5_eoi", isr_o, 8'h00);
    step();
    check("t5_int7", int_o, 1);
    do_ack();
    check("t5_vec7", vec_out, 8'h27);
    check("t5_spur7", spurious, 0);
    check("t5_isr7", isr_o, 8'h80);
    do_eoi(1'b0, 3'd0);
    step();

    // 6: reset during VECTOR drops pending ir6 edge
    pulse_ir(8'h08);
    check("t6_int", int_o, 1);
    ir = 8'h40;
    do_ack();
    check("t6_vv", vec_valid, 1);
    ir = 8'h00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_vv", vec_valid, 0);
    check("t6_int", int_o, 0);
    check("t6_isr", isr_o, 8'h00);
    check("t6_pri", cur_pri, 3'd7);
    check("t6_vec", vec_out, 8'h00);
    step(); step(); step();
    check("t6_lost", int_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/picc_isr_ctrl.md
Name: picc_isr_ctrl

Overview:
Interrupt sequencing controller for the 8-line PICC. It latches request lines into a pending register (IRR), selects the winner by fixed priority (ir0 highest, ir7 lowest) and raises the CPU interrupt. It then runs the acknowledge/vector handshake, tracks in-service levels (ISR) for nesting, and retires them on end-of-interrupt (EOI). Mask and trigger mode come from the Wishbone register block; the current in-service priority is exported to that block.

Parameters:
NUM_IRQ, 8, number of request lines (fixed at 8 in this revision; index width 3)
VEC_W, 8, width of returned vector
VEC_BASE, 8'h20, vector = VEC_BASE + line index

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ir  in  8  raw interrupt request lines, bit n = irn
mask  in  8  1 = line enabled
trig_mode  in  8  1 = rising-edge triggered, 0 = level triggered
int_o  out  1  interrupt request to CPU, registered
int_ack  in  1  one-cycle CPU acknowledge pulse
vec_valid  out  1  one-cycle pulse, vec_out valid
vec_out  out  VEC_W  interrupt vector
spurious  out  1  qualifies vec_valid: acknowledge with no valid candidate
eoi  in  1  one-cycle end-of-interrupt pulse
eoi_specific  in  1  with eoi: 1 = clear ISR bit eoi_id, 0 = clear highest-priority ISR bit
eoi_id  in  3  line index for specific EOI
isr_o  out  8  in-service register
cur_pri  out  3  index of highest-priority in-service line; 7 when ISR empty
in_service  out  1  ISR != 0

Behaviour:
- Reset (sync): ir_q, IRR, ISR = 0; FSM = IDLE; int_o, vec_valid, spurious = 0; vec_out = 0; cur_pri = 7. Reset in any state aborts the handshake, and the next cycle matches the reset values.
- Input stage: ir is registered into ir_q every cycle. Edge lines: IRR[n] is set when ir[n] & ~ir_q[n], and cleared when line n is acknowledged; set wins over clear in the same cycle. Level lines: IRR[n] <= ir[n] each cycle, with no latching.
- Candidate set = IRR & mask & ~ISR. Winner = lowest set index. The winner is allowed if ISR == 0 or winner index < cur_pri (strictly higher priority only, so nested; equal or lower waits).
- Latency: an ir rise before edge k sets IRR at edge k, and int_o goes high after edge k+1 if allowed.
- FSM:
  - IDLE: if allowed, go to ASSERT with int_o <= 1.
  - ASSERT: int_o = 1.
    - On int_ack with allowed winner w: go to VECTOR, vec_out <= VEC_BASE + w, ISR[w] <= 1, edge IRR[w] <= 0, int_o <= 0.
    - On int_ack with no allowed winner: go to VECTOR, vec_out <= VEC_BASE + 7, spurious <= 1, ISR unchanged.
    - Otherwise, if no allowed winner: go to IDLE with int_o <= 0.
    - Winner is evaluated combinationally in the int_ack cycle, so a higher-priority arrival before ack replaces the original.
  - VECTOR: vec_valid = 1 for exactly one cycle, then go to IDLE.
- int_ack in IDLE or VECTOR is ignored; no vector is produced.
- EOI: non-specific clears the lowest-index set ISR bit. Specific clears ISR[eoi_id]. EOI with ISR empty, or on a clear bit, is a no-op. EOI and ack in the same cycle: the EOI is computed from the pre-update ISR, then the ack bit is ORed in.
- Mask changes take effect on the next candidate evaluation. Masking a line does not clear its ISR or IRR bit.
- cur_pri, in_service and isr_o are derived from the registered ISR.

Decomposition:
- Package picc_pkg holds: NUM_IRQ, IDX_W = 3, the FSM state enum (IDLE, ASSERT, VECTOR), and constant PRI_NONE = 3'd7.
- Sub-module picc_ffs8 is a find-first-set priority encoder: 8-bit in, 3-bit index plus valid out. It is instantiated twice, once for the candidate winner and once for cur_pri / non-specific EOI.

Test Plan:
1. mask=FF, trig_mode=FF; pulse ir[3] -> int_o high 2 cycles later. int_ack -> next cycle vec_valid=1, vec_out=0x23, isr_o=0x08, int_o=0, IRR[3]=0.
2. isr_o=0x20 (ir5 in service). ir6 edge -> int_o stays 0. ir2 edge -> int_o=1; ack gives vec 0x22, isr_o=0x24, cur_pri=2.
3. Level ir1 (trig_mode[1]=0): ir1 high, then low when int_o rises; int_ack in the cycle IRR[1] drops -> vec_out=0x27, spurious=1, isr_o unchanged.
4. isr_o=0x24. Non-specific EOI -> isr_o=0x20. Specific EOI id 5 -> 0x00. EOI again -> no change, in_service=0.
5. ir0 and ir7 edges in the same cycle -> first ack gives 0x20. ir7 is held off until EOI; then int_o=1 and ack gives 0x27.
6. rst asserted in the VECTOR cycle -> next cycle vec_valid=0, int_o=0, isr_o=0, cur_pri=7. A pending edge request is lost.
